// File: rtl/udma_uart_rx_pkg.sv
// Shared types and helpers for the oversampling uDMA UART receiver.
package udma_uart_rx_pkg;

  localparam int unsigned MIN_BITS = 5;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    BREAK
  } rx_state_e;

  // Data bits per char from the 3-bit config field, clamped to the build maximum.
  function automatic logic [3:0] bits_from_cfg(input logic [2:0] cfg_bits, input int unsigned max_bits);
    int unsigned n;
    n = 32'(cfg_bits) + MIN_BITS;
    if (n > max_bits) n = max_bits;
    return 4'(n);
  endfunction

endpackage

// File: rtl/udma_uart_rx_fifo.sv
// Synchronous first-word fall-through RX FIFO with occupancy output.
module udma_uart_rx_fifo #(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic [DATA_W-1:0]       data_i,
  input  logic                    pop_i,
  output logic [DATA_W-1:0]       data_o,
  output logic                    valid_o,
  output logic                    full_o,
  output logic [$clog2(DEPTH):0]  level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic              w_push;
  logic              w_pop;

  assign valid_o = (r_level != '0);
  assign full_o  = (r_level == LW'(DEPTH));
  assign level_o = r_level;
  assign data_o  = valid_o ? r_mem[r_rd_ptr] : '0;
  assign w_pop   = pop_i && valid_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign w_push  = push_i && (!full_o || w_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/udma_uart_rx_os.sv
// Oversampling UART receiver with majority vote, error detection and RX FIFO.
// Optional idle timeout enabled with UDMA_UART_RX_TIMEOUT_EN.
module udma_uart_rx_os
  import udma_uart_rx_pkg::*;
#(
  parameter int unsigned DATA_W = 9,
  parameter int unsigned OS     = 16,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    rx_i,
  input  logic                    cfg_en_i,
  input  logic [15:0]             cfg_div_i,
  input  logic [2:0]              cfg_bits_i,
  input  logic                    cfg_parity_en_i,
  input  logic                    cfg_parity_odd_i,
  input  logic                    cfg_stop_bits_i,
  output logic [DATA_W-1:0]       rx_data_o,
  output logic                    rx_valid_o,
  input  logic                    rx_ready_i,
  output logic [$clog2(DEPTH):0]  fifo_level_o,
  output logic                    busy_o,
  output logic                    char_event_o,
  output logic                    err_parity_o,
  output logic                    err_frame_o,
  output logic                    err_overflow_o,
  output logic                    err_noise_o,
  output logic                    break_o
`ifdef UDMA_UART_RX_TIMEOUT_EN
  ,
  input  logic [7:0]              cfg_timeout_i,
  output logic                    timeout_o
`endif
);

  localparam int unsigned PH_W = $clog2(OS);
  localparam logic [PH_W-1:0] PH_S0   = PH_W'(OS/2 - 1);
  localparam logic [PH_W-1:0] PH_S1   = PH_W'(OS/2);
  localparam logic [PH_W-1:0] PH_S2   = PH_W'(OS/2 + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OS - 1);

  rx_state_e         r_state, w_state_nxt;
  logic              r_sync1, r_sync2, r_hist;
  logic [15:0]       r_div_cnt, w_div_nxt;
  logic [PH_W-1:0]   r_phase, w_phase_nxt;
  logic              r_s0, r_s1, w_s0_nxt, w_s1_nxt;
  logic [3:0]        r_bit_cnt, w_bit_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic              r_parity, w_parity_nxt;
  logic              r_par_bit, w_par_bit_nxt;
  logic              r_par_err, w_par_err_nxt;
  logic              r_noise, w_noise_nxt;
  logic              r_char_event, r_err_parity, r_err_frame, r_err_overflow, r_err_noise, r_break;
  logic              w_char, w_perr, w_ferr, w_ovf, w_nerr, w_brk;
  logic              w_fall, w_run, w_to_run, w_tick, w_dec, w_bit_end, w_maj, w_dis;
  logic              w_finish, w_fin_noise, w_push, w_pop, w_full;
  logic [3:0]        w_nbits;

`ifdef UDMA_UART_RX_TIMEOUT_EN
  logic [7:0]        r_to_bits, w_to_bits_nxt;
  logic              r_to_done, w_to_done_nxt, r_timeout, w_timeout;
  assign w_to_run  = cfg_en_i && (r_state == IDLE) && rx_valid_o && (cfg_timeout_i != 8'd0) && !r_to_done;
  assign timeout_o = r_timeout;
`else
  assign w_to_run  = 1'b0;
`endif

  assign w_fall    = r_hist && !r_sync2;
  assign w_run     = (r_state != IDLE) || w_to_run;
  assign w_tick    = w_run && (r_div_cnt == cfg_div_i);
  assign w_dec     = w_tick && (r_phase == PH_S2);
  assign w_bit_end = w_tick && (r_phase == PH_LAST);
  assign w_maj     = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);
  assign w_dis     = !((r_s0 == r_s1) && (r_s1 == r_sync2));
  assign w_nbits   = bits_from_cfg(cfg_bits_i, DATA_W);
  assign w_pop     = rx_ready_i && rx_valid_o;

  always_comb begin
    w_state_nxt   = r_state;
    w_div_nxt     = r_div_cnt;
    w_phase_nxt   = r_phase;
    w_s0_nxt      = r_s0;
    w_s1_nxt      = r_s1;
    w_bit_nxt     = r_bit_cnt;
    w_data_nxt    = r_data;
    w_parity_nxt  = r_parity;
    w_par_bit_nxt = r_par_bit;
    w_par_err_nxt = r_par_err;
    w_noise_nxt   = r_noise;
    w_finish      = 1'b0;
    w_fin_noise   = 1'b0;
    w_push        = 1'b0;
    w_char        = 1'b0;
    w_perr        = 1'b0;
    w_ferr        = 1'b0;
    w_ovf         = 1'b0;
    w_nerr        = 1'b0;
    w_brk         = 1'b0;

    if (w_run) begin
      if (w_tick) begin
        w_div_nxt   = '0;
        w_phase_nxt = r_phase + PH_W'(1);
      end else begin
        w_div_nxt   = r_div_cnt + 16'd1;
      end
    end
    if (w_tick && (r_phase == PH_S0)) w_s0_nxt = r_sync2;
    if (w_tick && (r_phase == PH_S1)) w_s1_nxt = r_sync2;

    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_nxt   = START;
          w_div_nxt     = '0;
          w_phase_nxt   = '0;
          w_bit_nxt     = '0;
          w_data_nxt    = '0;
          w_parity_nxt  = 1'b0;
          w_par_bit_nxt = 1'b0;
          w_par_err_nxt = 1'b0;
          w_noise_nxt   = 1'b0;
        end
      end
      START: begin
        if (w_dec) begin
          if (w_maj) w_state_nxt = IDLE;
          else       w_noise_nxt = r_noise | w_dis;
        end
        if (w_bit_end) w_state_nxt = DATA;
      end
      DATA: begin
        if (w_dec) begin
          w_data_nxt   = r_data | (DATA_W'(w_maj) << r_bit_cnt);
          w_parity_nxt = r_parity ^ w_maj;
          w_noise_nxt  = r_noise | w_dis;
        end
        if (w_bit_end) begin
          if (r_bit_cnt == (w_nbits - 4'd1)) begin
            w_state_nxt = cfg_parity_en_i ? PARITY : STOP1;
          end else begin
            w_bit_nxt = r_bit_cnt + 4'd1;
          end
        end
      end
      PARITY: begin
        if (w_dec) begin
          w_par_err_nxt = r_parity ^ w_maj ^ cfg_parity_odd_i;
          w_par_bit_nxt = w_maj;
          w_noise_nxt   = r_noise | w_dis;
        end
        if (w_bit_end) w_state_nxt = STOP1;
      end
      STOP1: begin
        if (w_dec) begin
          if (!w_maj) begin
            // An all-zero frame with a low stop bit is a line break, not a framing error.
            if ((r_data == '0) && (!cfg_parity_en_i || !r_par_bit)) begin
              w_brk       = 1'b1;
              w_state_nxt = BREAK;
            end else begin
              w_ferr      = 1'b1;
              w_state_nxt = IDLE;
            end
          end else if (cfg_stop_bits_i) begin
            w_noise_nxt = r_noise | w_dis;
          end else begin
            w_finish    = 1'b1;
            w_fin_noise = r_noise | w_dis;
            w_state_nxt = IDLE;
          end
        end
        if (w_bit_end) w_state_nxt = STOP2;
      end
      STOP2: begin
        if (w_dec) begin
          if (!w_maj) begin
            w_ferr      = 1'b1;
          end else begin
            w_finish    = 1'b1;
            w_fin_noise = r_noise | w_dis;
          end
          w_state_nxt = IDLE;
        end
      end
      BREAK: begin
        if (r_sync2) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_finish) begin
      if (r_par_err) begin
        w_perr = 1'b1;
      end else if (w_full && !w_pop) begin
        w_ovf  = 1'b1;
      end else begin
        w_push = 1'b1;
        w_char = 1'b1;
        w_nerr = w_fin_noise;
      end
    end

`ifdef UDMA_UART_RX_TIMEOUT_EN
    w_to_bits_nxt = r_to_bits;
    w_to_done_nxt = r_to_done;
    w_timeout     = 1'b0;
    if (!cfg_en_i || w_fall || w_pop || !rx_valid_o) begin
      w_to_bits_nxt = '0;
      w_to_done_nxt = 1'b0;
      if ((r_state == IDLE) && w_pop) begin
        w_div_nxt   = '0;
        w_phase_nxt = '0;
      end
    end else if (w_to_run && w_bit_end) begin
      if ((r_to_bits + 8'd1) == cfg_timeout_i) begin
        w_timeout     = 1'b1;
        w_to_done_nxt = 1'b1;
      end else begin
        w_to_bits_nxt = r_to_bits + 8'd1;
      end
    end
`endif

    // Disabling abandons any frame silently.
    if (!cfg_en_i) begin
      w_state_nxt = IDLE;
      w_push      = 1'b0;
      w_char      = 1'b0;
      w_perr      = 1'b0;
      w_ferr      = 1'b0;
      w_ovf       = 1'b0;
      w_nerr      = 1'b0;
      w_brk       = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= IDLE;
      r_sync1        <= 1'b1;
      r_sync2        <= 1'b1;
      r_hist         <= 1'b1;
      r_div_cnt      <= '0;
      r_phase        <= '0;
      r_s0           <= 1'b1;
      r_s1           <= 1'b1;
      r_bit_cnt      <= '0;
      r_data         <= '0;
      r_parity       <= 1'b0;
      r_par_bit      <= 1'b0;
      r_par_err      <= 1'b0;
      r_noise        <= 1'b0;
      r_char_event   <= 1'b0;
      r_err_parity   <= 1'b0;
      r_err_frame    <= 1'b0;
      r_err_overflow <= 1'b0;
      r_err_noise    <= 1'b0;
      r_break        <= 1'b0;
    end else begin
      if (!cfg_en_i) begin
        r_sync1 <= 1'b1;
        r_sync2 <= 1'b1;
        r_hist  <= 1'b1;
      end else begin
        r_sync1 <= rx_i;
        r_sync2 <= r_sync1;
        r_hist  <= r_sync2;
      end
      r_state        <= w_state_nxt;
      r_div_cnt      <= w_div_nxt;
      r_phase        <= w_phase_nxt;
      r_s0           <= w_s0_nxt;
      r_s1           <= w_s1_nxt;
      r_bit_cnt      <= w_bit_nxt;
      r_data         <= w_data_nxt;
      r_parity       <= w_parity_nxt;
      r_par_bit      <= w_par_bit_nxt;
      r_par_err      <= w_par_err_nxt;
      r_noise        <= w_noise_nxt;
      r_char_event   <= w_char;
      r_err_parity   <= w_perr;
      r_err_frame    <= w_ferr;
      r_err_overflow <= w_ovf;
      r_err_noise    <= w_nerr;
      r_break        <= w_brk;
    end
  end

`ifdef UDMA_UART_RX_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_to_bits <= '0;
      r_to_done <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_to_bits <= w_to_bits_nxt;
      r_to_done <= w_to_done_nxt;
      r_timeout <= w_timeout;
    end
  end
`endif

  assign busy_o         = (r_state != IDLE);
  assign char_event_o   = r_char_event;
  assign err_parity_o   = r_err_parity;
  assign err_frame_o    = r_err_frame;
  assign err_overflow_o = r_err_overflow;
  assign err_noise_o    = r_err_noise;
  assign break_o        = r_break;

  udma_uart_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (!cfg_en_i),
    .push_i  (w_push),
    .data_i  (r_data),
    .pop_i   (rx_ready_i),
    .data_o  (rx_data_o),
    .valid_o (rx_valid_o),
    .full_o  (w_full),
    .level_o (fifo_level_o)
  );

endmodule

// File: tb/tb_udma_uart_rx_os.sv
// Scoreboard bench for udma_uart_rx_os: frame-level model predicts events and popped data.
module tb_udma_uart_rx_os;

  localparam int unsigned DATA_W = 9;
  localparam int unsigned OS     = 16;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned LW     = $clog2(DEPTH) + 1;

  localparam logic [5:0] EV_CHAR  = 6'b000001;
  localparam logic [5:0] EV_PAR   = 6'b000010;
  localparam logic [5:0] EV_FRM   = 6'b000100;
  localparam logic [5:0] EV_OVF   = 6'b001000;
  localparam logic [5:0] EV_BRK   = 6'b010000;
  localparam logic [5:0] EV_NOISE = 6'b100000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx = 1'b1;
  logic              en = 1'b0;
  logic              ready = 1'b0;
  logic [15:0]       div = 16'd3;
  logic [2:0]        bits = 3'd3;
  logic              pen = 1'b0;
  logic              podd = 1'b0;
  logic              stops = 1'b0;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic [LW-1:0]     level;
  logic              busy, cev, eperr, eferr, eovf, enoise, ebrk;

  int checks = 0;
  int errors = 0;
  int model_level = 0;
  logic [5:0]        exp_ev[$];
  logic [DATA_W-1:0] exp_data[$];

  always #5 clk = ~clk;

  udma_uart_rx_os #(.DATA_W(DATA_W), .OS(OS), .DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .rx_i             (rx),
    .cfg_en_i         (en),
    .cfg_div_i        (div),
    .cfg_bits_i       (bits),
    .cfg_parity_en_i  (pen),
    .cfg_parity_odd_i (podd),
    .cfg_stop_bits_i  (stops),
    .rx_data_o        (rdata),
    .rx_valid_o       (rvalid),
    .rx_ready_i       (ready),
    .fifo_level_o     (level),
    .busy_o           (busy),
    .char_event_o     (cev),
    .err_parity_o     (eperr),
    .err_frame_o      (eferr),
    .err_overflow_o   (eovf),
    .err_noise_o      (enoise),
    .break_o          (ebrk)
  );

  // Monitor: every pulse set and every pop is compared against the scoreboard queues.
  always @(negedge clk) begin : mon
    logic [5:0]        obs;
    logic [5:0]        want;
    logic [DATA_W-1:0] wd;
    obs = {enoise, ebrk, eovf, eferr, eperr, cev};
    if (!rst && obs != 6'd0) begin
      checks++;
      if (exp_ev.size() == 0) begin
        errors++;
        $display("FAIL event: got %b expected none", obs);
      end else begin
        want = exp_ev.pop_front();
        if (obs !== want) begin
          errors++;
          $display("FAIL event: got %b expected %b", obs, want);
        end
      end
    end
    if (!rst && rvalid && ready) begin
      checks++;
      if (exp_data.size() == 0) begin
        errors++;
        $display("FAIL pop_data: got %h expected none", rdata);
      end else begin
        wd = exp_data.pop_front();
        if (rdata !== wd) begin
          errors++;
          $display("FAIL pop_data: got %h expected %h", rdata, wd);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int nbits();
    int n;
    n = int'(bits) + 5;
    if (n > int'(DATA_W)) n = int'(DATA_W);
    return n;
  endfunction

  function automatic int tck();
    return int'(div) + 1;
  endfunction

  // Frame-level reference: which single outcome the frame produces, and the stored char.
  task automatic expect_frame(input logic [DATA_W-1:0] d, input logic flip, input int bad_stop,
                              input logic noise);
    logic [DATA_W-1:0] dm;
    logic              pb;
    logic [5:0]        ev;
    dm = '0;
    for (int i = 0; i < nbits(); i++) dm[i] = d[i];
    pb = (^dm) ^ podd ^ flip;
    if (bad_stop == 1)                ev = (dm == '0 && (!pen || !pb)) ? EV_BRK : EV_FRM;
    else if (bad_stop == 2 && stops)  ev = EV_FRM;
    else if (pen && flip)             ev = EV_PAR;
    else if (model_level >= int'(DEPTH)) ev = EV_OVF;
    else begin
      ev = noise ? (EV_CHAR | EV_NOISE) : EV_CHAR;
      exp_data.push_back(dm);
      if (!ready) model_level++;
    end
    exp_ev.push_back(ev);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input int glitch, input logic flip,
                            input int bad_stop);
    logic q[$];
    logic pb;
    int   t, bt;
    t  = tck();
    bt = int'(OS) * t;
    pb = 1'b0;
    q.push_back(1'b0);
    for (int i = 0; i < nbits(); i++) begin
      q.push_back(d[i]);
      pb ^= d[i];
    end
    if (pen) q.push_back(pb ^ podd ^ flip);
    q.push_back(bad_stop != 1);
    if (stops) q.push_back(bad_stop != 2);
    for (int i = 0; i < q.size(); i++) begin
      rx = q[i];
      if (i == glitch) begin
        cyc(8 * t + 2);
        rx = ~q[i];
        cyc(t);
        rx = q[i];
        cyc(bt - 9 * t - 2);
      end else begin
        cyc(bt);
      end
    end
    rx = 1'b1;
    cyc(2 * bt);
  endtask

  task automatic frame(input logic [DATA_W-1:0] d, input int glitch, input logic flip,
                       input int bad_stop);
    expect_frame(d, flip, bad_stop, glitch >= 0);
    send_frame(d, glitch, flip, bad_stop);
  endtask

  task automatic drain();
    int k;
    ready = 1'b1;
    k = 0;
    while (rvalid && k < 64) begin
      cyc(1);
      k++;
    end
    chk("drain_empty", 32'(rvalid), 32'(0));
    model_level = 0;
  endtask

  initial begin
    int bt;
    logic [DATA_W-1:0] d;
    logic flip;
    int bad;

    rst = 1'b1;
    cyc(4);
    chk("rst_valid", 32'(rvalid), 32'(0));
    chk("rst_level", 32'(level), 32'(0));
    chk("rst_busy",  32'(busy),  32'(0));
    chk("rst_data",  32'(rdata), 32'(0));
    chk("rst_pulses", 32'({enoise, ebrk, eovf, eferr, eperr, cev}), 32'(0));

    rst = 1'b0;
    en = 1'b1;
    ready = 1'b1;
    cyc(10);

    // 8N1 basic char
    frame(9'h0A5, -1, 1'b0, 0);

    // 9E2: good parity kept, bad parity dropped
    ready = 1'b0;
    model_level = 0;
    bits = 3'd4; pen = 1'b1; podd = 1'b0; stops = 1'b1;
    cyc(4);
    frame(9'h1FF, -1, 1'b0, 0);
    frame(9'h1FF, -1, 1'b1, 0);
    chk("parity_level", 32'(level), 32'(1));
    drain();

    // framing error, then held-low line gives a single break
    bits = 3'd3; pen = 1'b0; stops = 1'b0;
    cyc(4);
    bt = int'(OS) * tck();
    frame(9'h03C, -1, 1'b0, 1);
    exp_ev.push_back(EV_BRK);
    rx = 1'b0;
    cyc(20 * bt);
    chk("break_busy_low", 32'(busy), 32'(1));
    rx = 1'b1;
    cyc(1);
    chk("break_busy_hold", 32'(busy), 32'(1));
    cyc(5);
    chk("break_busy_idle", 32'(busy), 32'(0));
    cyc(bt);

    // idle glitch is a false start; data glitch is outvoted but flagged
    rx = 1'b0;
    cyc(tck());
    rx = 1'b1;
    cyc(3 * bt);
    chk("false_start_idle", 32'(busy), 32'(0));
    frame(9'h05A, 3, 1'b0, 0);

    // overflow on the ninth char with no reads, then ordered drain
    ready = 1'b0;
    model_level = 0;
    for (int i = 0; i < 9; i++) frame(DATA_W'(i), -1, 1'b0, 0);
    chk("ovf_level", 32'(level), 32'(8));
    drain();

    // disable mid-frame flushes FIFO and abandons the frame silently
    ready = 1'b0;
    model_level = 0;
    frame(9'h011, -1, 1'b0, 0);
    rx = 1'b0; cyc(bt);
    rx = 1'b1; cyc(bt);
    rx = 1'b0; cyc(bt);
    rx = 1'b1; cyc(bt);
    rx = 1'b0; cyc(bt / 2);
    chk("dis_busy_before", 32'(busy), 32'(1));
    chk("dis_level_before", 32'(level), 32'(1));
    en = 1'b0;
    cyc(1);
    chk("dis_busy_after", 32'(busy), 32'(0));
    chk("dis_level_after", 32'(level), 32'(0));
    chk("dis_valid_after", 32'(rvalid), 32'(0));
    exp_data.delete();
    model_level = 0;
    rx = 1'b1;
    cyc(10);
    en = 1'b1;
    ready = 1'b1;
    cyc(10);
    frame(9'h055, -1, 1'b0, 0);

    // randomized formats, parity faults, stop faults and zero chars
    for (int it = 0; it < 16; it++) begin
      bits  = 3'($urandom_range(0, 7));
      pen   = 1'($urandom_range(0, 1));
      podd  = 1'($urandom_range(0, 1));
      stops = 1'($urandom_range(0, 1));
      div   = 16'($urandom_range(1, 3));
      cyc(4);
      d = DATA_W'($urandom);
      if ($urandom_range(0, 5) == 0) d = '0;
      flip = pen && ($urandom_range(0, 4) == 0);
      bad = 0;
      if ($urandom_range(0, 5) == 0) bad = stops ? int'($urandom_range(1, 2)) : 1;
      frame(d, -1, flip, bad);
    end

    cyc(100);
    chk("events_pending", 32'(exp_ev.size()), 32'(0));
    chk("data_pending", 32'(exp_data.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
